multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, instruction register (IR), and PC, driven through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states. It replaces the single-cycle main decoder for the multi-cycle build and covers R-type, ADDI, ANDI, ORI, LW, SW, BEQ, BNE and J. It also handles a variable-latency memory through a ready handshake. ALU control and register-file sub-blocks are unchanged apart from the ALUOp encoding below.

---
 rtl/mc_pkg.sv | 78 +++++++
 rtl/multicycle_control_out_decode.sv | 80 ++++++++
 rtl/multicycle_control.sv | 108 ++++++++++
 tb/tb_multicycle_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencing controller:
// opcodes, state codes, datapath mux encodings and the control-word layout.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IMMEXEC = 4'd10,
        S_IMMWB   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_LOGIC = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_t;

    typedef struct packed {
        logic   pc_write;
        logic   pc_write_cond;
        logic   branch_ne;
        logic   i_or_d;
        logic   mem_read;
        logic   mem_write;
        logic   ir_write;
        logic   mem_to_reg;
        logic   reg_dest;
        logic   reg_write;
        logic   alu_src_a;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        pcsrc_t pc_source;
        logic   instr_done;
        logic   illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: is_supported = 1'b1;
            default:                       is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_out_decode.sv
// Combinational control-word decode from the current state; MemReady only
// qualifies the IR/PC load in FETCH and the completion pulse in MEMWR.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // ALU speculatively forms PC+4 + (imm<<2) for a possible branch
                o_ctrl.alu_src_b  = SRCB_IMM_SH2;
                o_ctrl.illegal_op = ~is_supported(i_opcode);
                o_ctrl.instr_done = ~is_supported(i_opcode);
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.i_or_d     = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            S_RTEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dest   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.branch_ne     = i_opcode[0];
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.instr_done = 1'b1;
            end
            S_IMMEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = (i_opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_LOGIC;
            end
            S_IMMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register and next-state logic; the
// control word comes from mc_out_decode and is forced to zero under Reset.
//
//  state    | meaning
//  FETCH    | read IR from mem[PC], PC <= PC+4 on MemReady
//  DECODE   | read regs, precompute branch target, dispatch on opcode
//  MEMADR   | ALUOut <= A + sext(imm)
//  MEMRD    | MDR <= mem[ALUOut], wait for MemReady
//  MEMWB    | rt <= MDR
//  MEMWR    | mem[ALUOut] <= B, wait for MemReady
//  RTEXEC   | ALUOut <= A funct B
//  RTWB     | rd <= ALUOut
//  BRANCH   | compare A,B and conditionally load branch target
//  JUMP     | PC <= jump target
//  IMMEXEC  | ALUOut <= A op sext(imm)
//  IMMWB    | rt <= ALUOut
module multicycle_control
    import mc_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] OpCode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDest,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] StateOut
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl_raw;
    ctrl_t  w_ctrl;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:                w_next = S_RTEXEC;
                    OP_LW, OP_SW:            w_next = S_MEMADR;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IMMEXEC;
                    OP_BEQ, OP_BNE:          w_next = S_BRANCH;
                    OP_J:                    w_next = S_JUMP;
                    default:                 w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (OpCode == OP_LW)      w_next = S_MEMRD;
                else if (OpCode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:   w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = MemReady ? S_FETCH : S_MEMWR;
            S_RTEXEC:  w_next = S_RTWB;
            S_IMMEXEC: w_next = S_IMMWB;
            default:   w_next = S_FETCH;
        endcase
    end

    mc_out_decode u_out_decode (
        .i_state     (r_state),
        .i_opcode    (OpCode),
        .i_mem_ready (MemReady),
        .o_ctrl      (w_ctrl_raw)
    );

    // Gating here guarantees no write strobe while an instruction is aborted.
    assign w_ctrl = Reset ? '0 : w_ctrl_raw;

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign BranchNe    = w_ctrl.branch_ne;
    assign IorD        = w_ctrl.i_or_d;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemtoReg    = w_ctrl.mem_to_reg;
    assign RegDest     = w_ctrl.reg_dest;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCSource    = w_ctrl.pc_source;
    assign InstrDone   = w_ctrl.instr_done;
    assign IllegalOp   = w_ctrl.illegal_op;
    assign StateOut    = Reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the
// expected state and control word, the negedge monitor pops and compares.
module tb_multicycle_control;

    logic       Clk;
    logic       Reset;
    logic [5:0] OpCode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
    logic       IRWrite, MemtoReg, RegDest, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       InstrDone, IllegalOp;
    logic [3:0] StateOut;

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .OpCode(OpCode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDest(RegDest), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .InstrDone(InstrDone), .IllegalOp(IllegalOp), .StateOut(StateOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] cw;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   m_state  = 0;

    wire [18:0] dut_cw = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
                          IRWrite, MemtoReg, RegDest, RegWrite, ALUSrcA, ALUSrcB,
                          ALUOp, PCSource, InstrDone, IllegalOp};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic legal_op(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b001000 || op == 6'b001100 || op == 6'b001101 ||
               op == 6'b000100 || op == 6'b000101 || op == 6'b000010;
    endfunction

    // Expected outputs written directly from the per-state output lists.
    function automatic logic [18:0] model_cw(input int st, input logic [5:0] op,
                                             input logic rdy, input logic rst);
        logic pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, id, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, id, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        if (!rst) begin
            case (st)
                0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
                1:  begin asb = 2'b11; ill = !legal_op(op); id = !legal_op(op); end
                2:  begin asa = 1; asb = 2'b10; end
                3:  begin mr = 1; iord = 1; end
                4:  begin rw = 1; m2r = 1; id = 1; end
                5:  begin mw = 1; iord = 1; id = rdy; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rw = 1; rd = 1; id = 1; end
                8:  begin asa = 1; aop = 2'b01; pcwc = 1; bne = op[0]; pcs = 2'b01; id = 1; end
                9:  begin pcw = 1; pcs = 2'b10; id = 1; end
                10: begin asa = 1; asb = 2'b10; aop = (op == 6'b001000) ? 2'b00 : 2'b11; end
                11: begin rw = 1; id = 1; end
                default: ;
            endcase
        end
        return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, id, ill};
    endfunction

    function automatic int model_next(input int st, input logic [5:0] op, input logic rdy);
        case (st)
            0: return rdy ? 1 : 0;
            1: begin
                if (op == 6'b000000) return 6;
                if (op == 6'b100011 || op == 6'b101011) return 2;
                if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101) return 10;
                if (op == 6'b000100 || op == 6'b000101) return 8;
                if (op == 6'b000010) return 9;
                return 0;
            end
            2: return (op == 6'b100011) ? 3 : ((op == 6'b101011) ? 5 : 0);
            3: return rdy ? 4 : 3;
            5: return rdy ? 0 : 5;
            6: return 7;
            10: return 11;
            default: return 0;
        endcase
    endfunction

    task automatic step(input logic [5:0] op, input logic rdy, input logic rst);
        exp_t e;
        @(posedge Clk); #1;
        OpCode = op; MemReady = rdy; Reset = rst;
        e.st = rst ? 4'd0 : 4'(m_state);
        e.cw = model_cw(m_state, op, rdy, rst);
        sb.push_back(e);
        m_state = rst ? 0 : model_next(m_state, op, rdy);
    endtask

    // Runs one whole instruction with the given memory stall counts.
    task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw);
        int d0, prev;
        logic rdy;
        d0 = done_cnt;
        for (int i = 0; i < 30; i++) begin
            rdy = 1'b1;
            if (m_state == 0 && fw > 0) begin rdy = 1'b0; fw--; end
            else if ((m_state == 3 || m_state == 5) && mw > 0) begin rdy = 1'b0; mw--; end
            prev = m_state;
            step(op, rdy, 1'b0);
            if (prev != 0 && m_state == 0) break;
        end
        @(negedge Clk); #1;
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_eq("state", StateOut, mon_e.st);
            check_eq("ctrl", dut_cw, mon_e.cw);
            check_eq("mem_rw_excl", MemRead & MemWrite, 0);
            check_eq("irw_only_fetch", IRWrite & (StateOut != 4'd0), 0);
            if (InstrDone) done_cnt++;
        end
    end

    initial begin
        Reset = 1'b1; OpCode = 6'b000000; MemReady = 1'b1;
        repeat (3) step(6'b000000, 1'b1, 1'b1);

        run_instr("rtype", 6'b000000, 0, 0);
        run_instr("lw",    6'b100011, 2, 1);
        run_instr("sw",    6'b101011, 0, 0);
        run_instr("sw_st", 6'b101011, 1, 2);
        run_instr("bne",   6'b000101, 0, 0);
        run_instr("beq",   6'b000100, 0, 0);
        run_instr("ori",   6'b001101, 0, 0);
        run_instr("andi",  6'b001100, 0, 0);
        run_instr("addi",  6'b001000, 0, 0);
        run_instr("j",     6'b000010, 1, 0);
        run_instr("ill",   6'b111111, 0, 0);
        run_instr("lw2",   6'b100011, 0, 0);

        // Abort SW in MEMADR, then in MEMWR with MemReady high.
        step(6'b101011, 1'b1, 1'b0);
        step(6'b101011, 1'b1, 1'b0);
        step(6'b101011, 1'b1, 1'b1);
        run_instr("after_rst1", 6'b000000, 0, 0);
        step(6'b101011, 1'b1, 1'b0);
        step(6'b101011, 1'b1, 1'b0);
        step(6'b101011, 1'b1, 1'b0);
        step(6'b101011, 1'b1, 1'b1);
        run_instr("after_rst2", 6'b000010, 0, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge Clk);
        #1;
        check_eq("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
